rr_mux_arbiter: RTL and testbench

RR_MUX_ARBITER -- requirements
Module: rr_mux_arbiter

---
 rtl/rr_mux_arbiter_pkg.sv | 17 +
 rtl/rr_mux_arbiter_if.sv | 39 +++
 rtl/rr_mux_arbiter_mux.sv | 24 ++
 rtl/rr_mux_arbiter.sv | 107 ++++++++++
 tb/tb_rr_mux_arbiter.sv | 188 ++++++++++++++++++
 5 files changed

// File: rtl/rr_mux_arbiter_pkg.sv
// Shared encodings for the round-robin mux arbiter:
// FSM states, source indices and the grant pointer reset value.
package rr_mux_arbiter_pkg;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    localparam logic [1:0] SRC_A = 2'd0;
    localparam logic [1:0] SRC_B = 2'd1;
    localparam logic [1:0] SRC_C = 2'd2;
    localparam logic [1:0] SRC_D = 2'd3;

    localparam logic [1:0] LAST_GRANT_RST = SRC_D;

endpackage

// File: rtl/rr_mux_arbiter_if.sv
// Four-source request bundle plus the registered output channel.
// master is the arbiter side, slave the surrounding sources/sink.
interface rr_mux_arbiter_if #(
    parameter int b = 8
);
    logic         validA;
    logic         validB;
    logic         validC;
    logic         validD;
    logic [b-1:0] intA;
    logic [b-1:0] intB;
    logic [b-1:0] intC;
    logic [b-1:0] intD;
    logic         readyA;
    logic         readyB;
    logic         readyC;
    logic         readyD;
    logic         outValid;
    logic         outReady;
    logic [b-1:0] out;
    logic [1:0]   sel;

    modport master (
        input  validA, validB, validC, validD,
        input  intA, intB, intC, intD,
        input  outReady,
        output readyA, readyB, readyC, readyD,
        output outValid, out, sel
    );

    modport slave (
        output validA, validB, validC, validD,
        output intA, intB, intC, intD,
        output outReady,
        input  readyA, readyB, readyC, readyD,
        input  outValid, out, sel
    );

endinterface

// File: rtl/rr_mux_arbiter_mux.sv
// Plain 4-to-1 data multiplexer used by the arbiter data path.
module MUX_4_To_1 #(
    parameter int b = 8
) (
    input  logic [b-1:0] in_a,
    input  logic [b-1:0] in_b,
    input  logic [b-1:0] in_c,
    input  logic [b-1:0] in_d,
    input  logic [1:0]   sel,
    output logic [b-1:0] y
);

    always_comb begin
        y = in_a;
        unique case (sel)
            2'd0: y = in_a;
            2'd1: y = in_b;
            2'd2: y = in_c;
            2'd3: y = in_d;
            default: y = in_a;
        endcase
    end

endmodule

// File: rtl/rr_mux_arbiter.sv
// Round-robin arbiter over four sources feeding one registered
// output word; grants are combinational, data lands next edge.
module rr_mux_arbiter
    import rr_mux_arbiter_pkg::*;
#(
    parameter int b = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    rr_mux_arbiter_if.master  bus
);

    state_t       state;
    state_t       state_nxt;
    logic [1:0]   last_grant;
    logic [1:0]   grant_idx;
    logic [1:0]   cand;
    logic         grant_any;
    logic         load;
    logic         grant;
    logic [3:0]   valid_vec;
    logic [3:0]   ready_vec;
    logic [b-1:0] mux_out;
    logic [b-1:0] out_q;
    logic [1:0]   sel_q;

    assign valid_vec = {bus.validD, bus.validC, bus.validB, bus.validA};
    assign load      = (state == EMPTY) || bus.outReady;

    // Search starts one past the last winner and wraps mod 4.
    always_comb begin
        grant_any = 1'b0;
        grant_idx = last_grant;
        cand      = last_grant;
        for (int i = 1; i <= 4; i++) begin
            cand = last_grant + 2'(i);
            if (!grant_any && valid_vec[cand]) begin
                grant_any = 1'b1;
                grant_idx = cand;
            end
        end
    end

    assign grant = load && grant_any && rst_n;

    always_comb begin
        ready_vec = 4'b0000;
        if (grant) begin
            unique case (grant_idx)
                SRC_A: ready_vec = 4'b0001;
                SRC_B: ready_vec = 4'b0010;
                SRC_C: ready_vec = 4'b0100;
                SRC_D: ready_vec = 4'b1000;
                default: ready_vec = 4'b0000;
            endcase
        end
    end

    assign bus.readyA = ready_vec[0];
    assign bus.readyB = ready_vec[1];
    assign bus.readyC = ready_vec[2];
    assign bus.readyD = ready_vec[3];

    MUX_4_To_1 #(.b(b)) u_mux (
        .in_a (bus.intA),
        .in_b (bus.intB),
        .in_c (bus.intC),
        .in_d (bus.intD),
        .sel  (grant_idx),
        .y    (mux_out)
    );

    always_comb begin
        state_nxt = state;
        unique case (state)
            EMPTY: if (grant) state_nxt = FULL;
            FULL: begin
                if (grant)
                    state_nxt = FULL;
                else if (bus.outReady)
                    state_nxt = EMPTY;
            end
            default: state_nxt = EMPTY;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= EMPTY;
            out_q      <= '0;
            sel_q      <= SRC_A;
            last_grant <= LAST_GRANT_RST;
        end else begin
            state <= state_nxt;
            if (grant) begin
                out_q      <= mux_out;
                sel_q      <= grant_idx;
                last_grant <= grant_idx;
            end
        end
    end

    assign bus.outValid = (state == FULL);
    assign bus.out      = out_q;
    assign bus.sel      = sel_q;

endmodule

// File: tb/tb_rr_mux_arbiter.sv
// Scoreboard bench for rr_mux_arbiter: a round-robin reference
// model queues expected words at grant time, popped at output.
module tb_rr_mux_arbiter;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    rr_mux_arbiter_if #(.b(8)) bus ();

    rr_mux_arbiter #(.b(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        logic [7:0] data;
        logic [1:0] src;
    } word_t;

    word_t      sb[$];
    int         checks = 0;
    int         failures = 0;
    int         m_last;
    bit         m_full;
    logic [7:0] m_out;
    logic [1:0] m_sel;
    logic [7:0] d[4];

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=%0h expected=%0h at %0t",
                     tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_last = 3;
        m_full = 1'b0;
        m_out  = 8'h00;
        m_sel  = 2'd0;
        sb.delete();
    endtask

    task automatic drive(input logic [3:0] v, input logic ordy);
        bus.validA   = v[0];
        bus.validB   = v[1];
        bus.validC   = v[2];
        bus.validD   = v[3];
        bus.intA     = d[0];
        bus.intB     = d[1];
        bus.intC     = d[2];
        bus.intD     = d[3];
        bus.outReady = ordy;
    endtask

    function automatic logic [3:0] rdy_vec();
        return {bus.readyD, bus.readyC, bus.readyB, bus.readyA};
    endfunction

    // One cycle: drive, check grants, clock, check output.
    task automatic step(input string tag, input logic [3:0] v,
                        input logic ordy);
        bit         load;
        int         g;
        int         c;
        logic [3:0] exp_rdy;
        word_t      w;
        drive(v, ordy);
        #1;
        load = !m_full || ordy;
        g = -1;
        if (load) begin
            for (int k = 0; k < 4; k++) begin
                c = (m_last + 1 + k) % 4;
                if (g < 0 && v[c]) g = c;
            end
        end
        exp_rdy = 4'b0000;
        if (g >= 0) exp_rdy[g] = 1'b1;
        chk({tag, "_ready"}, 32'(rdy_vec()), 32'(exp_rdy));
        if (g >= 0) begin
            w.data = d[g];
            w.src  = 2'(g);
            sb.push_back(w);
            m_last = g;
            m_full = 1'b1;
        end else if (load) begin
            m_full = 1'b0;
        end
        @(posedge clk);
        #1;
        chk({tag, "_outValid"}, 32'(bus.outValid), 32'(m_full));
        if (g >= 0) begin
            if (sb.size() == 0) begin
                chk({tag, "_sb_empty"}, 32'(0), 32'(1));
            end else begin
                w = sb.pop_front();
                m_out = w.data;
                m_sel = w.src;
            end
        end
        chk({tag, "_out"}, 32'(bus.out), 32'(m_out));
        chk({tag, "_sel"}, 32'(bus.sel), 32'(m_sel));
    endtask

    initial begin
        d[0] = 8'h01;
        d[1] = 8'h02;
        d[2] = 8'h03;
        d[3] = 8'h04;
        model_reset();
        drive(4'b1111, 1'b1);
        #2;
        chk("rst_ready", 32'(rdy_vec()), 32'(0));
        chk("rst_outValid", 32'(bus.outValid), 32'(0));
        chk("rst_out", 32'(bus.out), 32'(0));
        chk("rst_sel", 32'(bus.sel), 32'(0));
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // All sources valid: 01,02,03,04,01 with sel 0,1,2,3,0.
        for (int i = 0; i < 5; i++) begin
            step("rr_all", 4'b1111, 1'b1);
            chk("rr_all_seq", 32'(bus.sel), 32'(i % 4));
        end

        d[2] = 8'hAA;
        for (int i = 0; i < 4; i++) begin
            step("only_c", 4'b0100, 1'b1);
            chk("only_c_out", 32'(bus.out), 32'hAA);
        end

        d[0] = 8'h11;
        d[1] = 8'h22;
        d[2] = 8'h33;
        d[3] = 8'h44;
        for (int i = 0; i < 3; i++)
            step("stall", 4'b1111, 1'b0);
        step("after_stall", 4'b1111, 1'b1);
        chk("after_stall_sel", 32'(bus.sel), 32'(3));

        step("set_c", 4'b0100, 1'b1);
        step("wrap_a", 4'b0011, 1'b1);
        chk("wrap_a_sel", 32'(bus.sel), 32'(0));
        step("then_b", 4'b0011, 1'b1);
        chk("then_b_sel", 32'(bus.sel), 32'(1));

        for (int i = 0; i < 4; i++)
            step("idle", 4'b0000, 1'(i % 2));
        chk("idle_outValid", 32'(bus.outValid), 32'(0));

        d[2] = 8'h03;
        step("load_03", 4'b0100, 1'b1);
        chk("pre_rst_out", 32'(bus.out), 32'h03);
        drive(4'b1111, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_outValid", 32'(bus.outValid), 32'(0));
        chk("async_out", 32'(bus.out), 32'(0));
        chk("async_sel", 32'(bus.sel), 32'(0));
        chk("async_ready", 32'(rdy_vec()), 32'(0));
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_reset();
        step("post_rst", 4'b1001, 1'b1);
        chk("post_rst_sel", 32'(bus.sel), 32'(0));

        for (int i = 0; i < 60; i++) begin
            for (int k = 0; k < 4; k++)
                d[k] = 8'($urandom_range(0, 255));
            step("rand", 4'($urandom_range(0, 15)),
                 1'($urandom_range(0, 1)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
